ahb_lite_master: RTL and testbench

- AHB-Lite manager that sits directly upstream of the slave-side AHB interface.
- Converts a simple valid/ready request stream (read/write, address, size, data) into pipelined address/data phases on haddr/htrans/hwrite/hsize/hwdata.
- Returns one response per completed transfer.
- Handles hready wait states and the two-cycle hresp error response.

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_master_addr_gen.sv | 46 ++++
 rtl/ahb_lite_master.sv | 179 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite types, encodings and address/data-phase register layouts
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Address-phase control; seq marks a continuation beat of an INCR burst.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic       seq;
    logic [2:0] size;
    logic [2:0] burst;
  } ap_ctrl_t;

  typedef struct packed {
    logic valid;
    logic write;
  } dp_ctrl_t;

  function automatic logic [2:0] max_hsize(input int data_w);
    if (data_w >= 64) return 3'($clog2(data_w / 8));
    if (data_w >= 32) return HSIZE_WORD;
    if (data_w >= 16) return HSIZE_HALF;
    return HSIZE_BYTE;
  endfunction

  function automatic logic [2:0] burst_for_len(input logic [3:0] len);
    return (len != 4'd0) ? HBURST_INCR : HBURST_SINGLE;
  endfunction

endpackage

// File: rtl/ahb_master_addr_gen.sv
// rtl/ahb_master_addr_gen.sv - INCR burst beat counter and wrapping address increment
module ahb_master_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              start,
  input  logic [3:0]        len,
  input  logic              advance,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] next_addr,
  output logic              active,
  output logic              active_d
);

  logic [3:0] cnt_q, cnt_d;

  // A new burst wins over a clear so a handshake during an error starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = len;
    end else if (clear) begin
      cnt_d = 4'd0;
    end else if (advance) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active    = (cnt_q != 4'd0);
  assign active_d  = (cnt_d != 4'd0);
  assign next_addr = addr + (ADDR_W'(1) << size);

endmodule

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - AHB-Lite manager turning a request stream into pipelined bus phases
// Optional INCR burst support (req_len, SEQ/BUSY) is built when AHB_MASTER_BURST_EN is defined.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef AHB_MASTER_BURST_EN
  input  logic [3:0]        req_len,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  localparam logic [2:0] MAX_HSIZE = max_hsize(DATA_W);

  ap_ctrl_t          ap_q, ap_d;
  dp_ctrl_t          dp_q, dp_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  htrans_t           htrans_q, htrans_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              err1, ap_issued, ap_done, dp_done, accept;
  logic              burst_cont, burst_active_d;
  logic [2:0]        first_burst;
  logic [ADDR_W-1:0] next_addr;

  assign err1      = dp_q.valid && hresp && !hready;
  assign ap_issued = (htrans_q == NONSEQ) || (htrans_q == SEQ);
  assign ap_done   = ap_q.valid && ap_issued && hready;
  assign dp_done   = dp_q.valid && hready;
  // A retracted AP (IDLE while the error finishes) still owns the slot until re-issued.
  assign req_ready = hreset_n && (!ap_q.valid || (hready && !err1 && ap_issued));
  assign accept    = req_valid && req_ready;

`ifdef AHB_MASTER_BURST_EN
  logic burst_active;

  ahb_master_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .start     (accept && !burst_cont),
    .len       (req_len),
    .advance   (accept && burst_cont),
    .clear     (err1 && !(ap_q.valid && !ap_q.seq)),
    .addr      (ap_addr_q),
    .size      (ap_q.size),
    .next_addr (next_addr),
    .active    (burst_active),
    .active_d  (burst_active_d)
  );

  assign burst_cont  = burst_active && !err1;
  assign first_burst = burst_for_len(req_len);
`else
  assign burst_cont     = 1'b0;
  assign burst_active_d = 1'b0;
  assign first_burst    = HBURST_SINGLE;
  assign next_addr      = ap_addr_q;
`endif

  always_comb begin
    ap_d        = ap_q;
    ap_addr_d   = ap_addr_q;
    ap_wdata_d  = ap_wdata_q;
    dp_d        = dp_q;
    dp_wdata_d  = dp_wdata_q;
    htrans_d    = IDLE;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    // Interrupted burst beats are dropped; a single NONSEQ is kept for re-issue.
    if (ap_done || (err1 && ap_q.seq)) begin
      ap_d.valid = 1'b0;
    end
    if (accept) begin
      ap_wdata_d = req_wdata;
      if (burst_cont) begin
        ap_d.valid = 1'b1;
        ap_d.seq   = 1'b1;
        ap_addr_d  = next_addr;
      end else begin
        ap_d      = '{valid: 1'b1, write: req_write, seq: 1'b0, size: req_size, burst: first_burst};
        ap_addr_d = req_addr;
      end
    end

    if (dp_done) begin
      dp_d.valid = 1'b0;
    end
    if (ap_done) begin
      dp_d       = '{valid: 1'b1, write: ap_q.write};
      dp_wdata_d = ap_wdata_q;
    end

    if (err1) begin
      htrans_d = IDLE;
    end else if (ap_d.valid) begin
      htrans_d = ap_d.seq ? SEQ : NONSEQ;
    end else if (burst_active_d) begin
      htrans_d = BUSY;
    end else begin
      htrans_d = IDLE;
    end

    if (dp_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = hresp;
      if (!dp_q.write && !hresp) begin
        rsp_rdata_d = hrdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      ap_q        <= '0;
      ap_addr_q   <= '0;
      ap_wdata_q  <= '0;
      dp_q        <= '0;
      dp_wdata_q  <= '0;
      htrans_q    <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_q        <= ap_d;
      ap_addr_q   <= ap_addr_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_q        <= dp_d;
      dp_wdata_q  <= dp_wdata_d;
      htrans_q    <= htrans_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset_n && accept && !burst_cont) begin
      assert (req_size <= MAX_HSIZE);
    end
  end

  assign haddr     = ap_addr_q;
  assign htrans    = htrans_q;
  assign hwrite    = ap_q.write;
  assign hsize     = ap_q.size;
  assign hburst    = ap_q.burst;
  assign hwdata    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - directed self-checking bench for ahb_lite_master
module tb_ahb_lite_master;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  logic              hclk = 1'b0;
  logic              hreset_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize, hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready, hresp;
  logic [DATA_W-1:0] hrdata;
`ifdef AHB_MASTER_BURST_EN
  logic [3:0]        req_len;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int rsp_count = 0;
  int exp_rsp = 0;

  always #5 hclk = ~hclk;

  ahb_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
`ifdef AHB_MASTER_BURST_EN
    .req_len   (req_len),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  always @(negedge hclk) begin
    if (rsp_valid === 1'b1) rsp_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic put_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_size  = 3'd0;
    req_wdata = d;
  endtask

  initial begin
    hreset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = 3'd0; req_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
`ifdef AHB_MASTER_BURST_EN
    req_len = 4'd0;
`endif
    tick(); tick();
    req_valid = 1'b1; #1;
    check_eq("rst_htrans", 32'(htrans), 0);
    check_eq("rst_haddr", 32'(haddr), 0);
    check_eq("rst_hwrite", 32'(hwrite), 0);
    check_eq("rst_hsize", 32'(hsize), 0);
    check_eq("rst_hburst", 32'(hburst), 0);
    check_eq("rst_hwdata", 32'(hwdata), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check_eq("rst_rsp_err", 32'(rsp_err), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    hreset_n = 1'b1; req_valid = 1'b0; #1;
    check_eq("idle_req_ready", 32'(req_ready), 1);

    // Single write addr=3 data=A5
    put_req(1'b1, 3'd3, 8'hA5);
    tick(); req_valid = 1'b0;
    check_eq("t1_htrans_c1", 32'(htrans), 2);
    check_eq("t1_haddr_c1", 32'(haddr), 3);
    check_eq("t1_hwrite_c1", 32'(hwrite), 1);
    tick();
    check_eq("t1_hwdata_c2", 32'(hwdata), 'hA5);
    check_eq("t1_htrans_c2", 32'(htrans), 0);
    check_eq("t1_rsp_c2", 32'(rsp_valid), 0);
    tick();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t1_rsp_err", 32'(rsp_err), 0);
    check_eq("t1_rsp_rdata", 32'(rsp_rdata), 0);
    tick();
    check_eq("t1_rsp_pulse", 32'(rsp_valid), 0);
    exp_rsp += 1;

    // Back-to-back read addr=1, write addr=2
    put_req(1'b0, 3'd1, 8'h00);
    tick();
    check_eq("t2_htrans_rd", 32'(htrans), 2);
    check_eq("t2_haddr_rd", 32'(haddr), 1);
    check_eq("t2_hwrite_rd", 32'(hwrite), 0);
    put_req(1'b1, 3'd2, 8'h11); #1;
    check_eq("t2_ready_b2b", 32'(req_ready), 1);
    tick(); req_valid = 1'b0; hrdata = 8'h3C;
    check_eq("t2_htrans_wr", 32'(htrans), 2);
    check_eq("t2_haddr_wr", 32'(haddr), 2);
    check_eq("t2_hwrite_wr", 32'(hwrite), 1);
    tick(); hrdata = 8'h77;
    check_eq("t2_rsp1_valid", 32'(rsp_valid), 1);
    check_eq("t2_rsp1_rdata", 32'(rsp_rdata), 'h3C);
    check_eq("t2_hwdata", 32'(hwdata), 'h11);
    tick();
    check_eq("t2_rsp2_valid", 32'(rsp_valid), 1);
    check_eq("t2_rsp2_rdata", 32'(rsp_rdata), 0);
    tick();
    exp_rsp += 2;

    // Read addr=6 with hready low for 3 cycles
    put_req(1'b0, 3'd6, 8'h00);
    tick(); req_valid = 1'b0; hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_hold_htrans", 32'(htrans), 2);
      check_eq("t3_hold_haddr", 32'(haddr), 6);
      check_eq("t3_hold_hwrite", 32'(hwrite), 0);
      check_eq("t3_hold_rsp", 32'(rsp_valid), 0);
      if (i == 2) hready = 1'b1;
    end
    tick(); hrdata = 8'h5A;
    check_eq("t3_htrans_dp", 32'(htrans), 0);
    tick();
    check_eq("t3_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t3_rsp_rdata", 32'(rsp_rdata), 'h5A);
    tick();
    check_eq("t3_rsp_pulse", 32'(rsp_valid), 0);
    exp_rsp += 1;

    // Write addr=4 errors with read addr=5 pending
    put_req(1'b1, 3'd4, 8'h44);
    tick();
    put_req(1'b0, 3'd5, 8'h00);
    tick(); req_valid = 1'b0; hresp = 1'b1; hready = 1'b0; #1;
    check_eq("t4_haddr_rd", 32'(haddr), 5);
    check_eq("t4_hwdata", 32'(hwdata), 'h44);
    check_eq("t4_ready_err1", 32'(req_ready), 0);
    tick(); hready = 1'b1;
    check_eq("t4_htrans_err2", 32'(htrans), 0);
    check_eq("t4_rsp_err2", 32'(rsp_valid), 0);
    tick(); hresp = 1'b0; hrdata = 8'hC3;
    check_eq("t4_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t4_rsp_err", 32'(rsp_err), 1);
    check_eq("t4_reissue_htrans", 32'(htrans), 2);
    check_eq("t4_reissue_haddr", 32'(haddr), 5);
    check_eq("t4_reissue_hwrite", 32'(hwrite), 0);
    tick();
    check_eq("t4_htrans_after", 32'(htrans), 0);
    check_eq("t4_rsp_gap", 32'(rsp_valid), 0);
    tick();
    check_eq("t4_rd_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t4_rd_rsp_err", 32'(rsp_err), 0);
    check_eq("t4_rd_rsp_rdata", 32'(rsp_rdata), 'hC3);
    tick();
    exp_rsp += 2;

`ifdef AHB_MASTER_BURST_EN
    // 4-beat INCR write from addr=6 with a request gap before beat 3
    put_req(1'b1, 3'd6, 8'h10); req_len = 4'd3;
    tick();
    check_eq("b_htrans_1", 32'(htrans), 2);
    check_eq("b_haddr_1", 32'(haddr), 6);
    check_eq("b_hburst", 32'(hburst), 1);
    req_wdata = 8'h11;
    tick(); req_valid = 1'b0;
    check_eq("b_htrans_2", 32'(htrans), 3);
    check_eq("b_haddr_2", 32'(haddr), 7);
    tick(); req_valid = 1'b1; req_wdata = 8'h12;
    check_eq("b_htrans_busy", 32'(htrans), 1);
    check_eq("b_haddr_busy", 32'(haddr), 7);
    tick(); req_wdata = 8'h13;
    check_eq("b_htrans_3", 32'(htrans), 3);
    check_eq("b_haddr_3", 32'(haddr), 0);
    tick(); req_valid = 1'b0; req_len = 4'd0;
    check_eq("b_htrans_4", 32'(htrans), 3);
    check_eq("b_haddr_4", 32'(haddr), 1);
    tick();
    check_eq("b_htrans_end", 32'(htrans), 0);
    tick(); tick(); tick();
    exp_rsp += 4;
`endif

    // Reset asserted during a data phase
    put_req(1'b1, 3'd7, 8'h99);
    tick(); req_valid = 1'b0;
    tick();
    check_eq("t5_hwdata", 32'(hwdata), 'h99);
    hreset_n = 1'b0; #1;
    check_eq("t5_ready_rst", 32'(req_ready), 0);
    tick(); req_valid = 1'b1; #1;
    check_eq("t5_htrans", 32'(htrans), 0);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 0);
    check_eq("t5_hwdata_clr", 32'(hwdata), 0);
    check_eq("t5_ready_hold", 32'(req_ready), 0);
    tick();
    check_eq("t5_htrans_2", 32'(htrans), 0);
    hreset_n = 1'b1; req_valid = 1'b0; #1;
    check_eq("t5_ready_rel", 32'(req_ready), 1);
    tick();
    check_eq("t5_no_rsp", 32'(rsp_valid), 0);
    tick(); tick();
    check_eq("rsp_total", 32'(rsp_count), 32'(exp_rsp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
